// File: rtl/key_debounce.sv
// key_debounce: two-flop synchroniser plus per-key stability counter for
// active-low push-buttons. Produces a registered active-high level, one-cycle
// press/release pulses and a per-key toggle that flips on every accepted press.
module key_debounce #(
    parameter int KEY_W        = 4,
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [KEY_W-1:0] key,
    output logic [KEY_W-1:0] key_level,
    output logic [KEY_W-1:0] key_press,
    output logic [KEY_W-1:0] key_release,
    output logic [KEY_W-1:0] key_toggle
);

    // Counter is wide enough to hold DEBOUNCE_CYC, so it can never wrap.
    localparam int             CW       = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};

    logic [KEY_W-1:0] sync1;
    logic [KEY_W-1:0] sync2;
    logic [KEY_W-1:0] key_db;
    logic [KEY_W-1:0] db_next;
    logic [KEY_W-1:0] accept;
    logic [CW-1:0]    cnt      [KEY_W];
    logic [CW-1:0]    cnt_next [KEY_W];

    // Two-stage synchroniser; released (all-ones) is the safe reset value.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1 <= {KEY_W{1'b1}};
            sync2 <= {KEY_W{1'b1}};
        end else begin
            sync1 <= key;
            sync2 <= sync1;
        end
    end

    // Next debounced state: accept a new value on the DEBOUNCE_CYC-th
    // consecutive mismatching cycle; any matching cycle restarts the count.
    always_comb begin
        db_next = key_db;
        accept  = {KEY_W{1'b0}};
        for (int i = 0; i < KEY_W; i++) begin
            cnt_next[i] = CNT_ZERO;
            if (sync2[i] == key_db[i]) begin
                cnt_next[i] = CNT_ZERO;
            end else if (cnt[i] == CNT_LAST) begin
                db_next[i]  = sync2[i];
                accept[i]   = 1'b1;
                cnt_next[i] = CNT_ZERO;
            end else begin
                cnt_next[i] = cnt[i] + CNT_ONE;
            end
        end
    end

    // Debounced state and stability counters.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            key_db <= {KEY_W{1'b1}};
            for (int i = 0; i < KEY_W; i++) begin
                cnt[i] <= CNT_ZERO;
            end
        end else begin
            key_db <= db_next;
            for (int i = 0; i < KEY_W; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    // Registered outputs, updated on the same edge as key_db so level and
    // pulses line up; a press is an accepted 1->0, a release an accepted 0->1.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            key_level   <= {KEY_W{1'b0}};
            key_press   <= {KEY_W{1'b0}};
            key_release <= {KEY_W{1'b0}};
            key_toggle  <= {KEY_W{1'b0}};
        end else begin
            key_level   <= ~db_next;
            key_press   <= accept & ~db_next;
            key_release <= accept & db_next;
            key_toggle  <= key_toggle ^ (accept & ~db_next);
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce (DEBOUNCE_CYC = 8, KEY_W = 4).
// Stimulus pushes expected pulse events (cycle, masks, level, toggle) into a
// queue; the monitor pops one entry whenever the DUT shows a pulse.
`timescale 1ns/1ps
module tb_key_debounce;

    localparam int KW  = 4;
    localparam int DC  = 8;
    localparam int LAT = DC + 2;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic [KW-1:0] key     = 4'hF;
    logic [KW-1:0] key_level;
    logic [KW-1:0] key_press;
    logic [KW-1:0] key_release;
    logic [KW-1:0] key_toggle;

    typedef struct {
        int          cyc;
        logic [3:0]  pm;
        logic [3:0]  rm;
        logic [3:0]  lv;
        logic [3:0]  tg;
    } exp_t;

    exp_t       q[$];
    int         cycle      = 0;
    int         checks     = 0;
    int         errors     = 0;
    int         probe_id   = 0;
    int         probe_seen = 0;
    logic       probe_final = 1'b0;
    logic [3:0] p_press = 4'h0;
    logic [3:0] p_rel   = 4'h0;
    logic [3:0] p_lvl   = 4'h0;
    logic [3:0] p_tog   = 4'h0;
    logic [3:0] m_lvl   = 4'h0;
    logic [3:0] m_tog   = 4'h0;

    key_debounce #(
        .KEY_W        (KW),
        .DEBOUNCE_CYC (DC)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .key         (key),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_toggle  (key_toggle)
    );

    always #5 sys_clk = ~sys_clk;

    // Cycle counter: number of rising edges seen so far.
    initial begin
        forever begin
            @(posedge sys_clk);
            cycle = cycle + 1;
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor: on every falling edge service probe requests and pop one
    // scoreboard entry for each cycle the DUT presents a pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge sys_clk);
            if (probe_id != probe_seen) begin
                probe_seen = probe_id;
                cmp("probe_press",   int'(key_press),   int'(p_press));
                cmp("probe_release", int'(key_release), int'(p_rel));
                cmp("probe_level",   int'(key_level),   int'(p_lvl));
                cmp("probe_toggle",  int'(key_toggle),  int'(p_tog));
                if (probe_final) begin
                    cmp("queue_empty", q.size(), 0);
                end
            end
            if ((key_press | key_release) != 4'h0) begin
                if (q.size() == 0) begin
                    cmp("unexpected_pulse", int'({key_press, key_release}), 0);
                end else begin
                    e = q.pop_front();
                    cmp("event_cycle",   cycle,              e.cyc);
                    cmp("event_press",   int'(key_press),    int'(e.pm));
                    cmp("event_release", int'(key_release),  int'(e.rm));
                    cmp("event_level",   int'(key_level),    int'(e.lv));
                    cmp("event_toggle",  int'(key_toggle),   int'(e.tg));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic expect_evt(input logic [3:0] pm, input logic [3:0] rm, input int at);
        m_tog = m_tog ^ pm;
        m_lvl = (m_lvl | pm) & ~rm;
        q.push_back('{cyc: at, pm: pm, rm: rm, lv: m_lvl, tg: m_tog});
    endtask

    task automatic probe(input logic [3:0] pr, input logic [3:0] rl,
                         input logic [3:0] lv, input logic [3:0] tg, input logic fin);
        p_press     = pr;
        p_rel       = rl;
        p_lvl       = lv;
        p_tog       = tg;
        probe_final = fin;
        probe_id    = probe_id + 1;
    endtask

    initial begin
        // Reset with keys released: all outputs zero.
        sys_rst = 1'b1;
        key     = 4'hF;
        tick(1);
        probe(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        tick(2);
        sys_rst = 1'b0;
        tick(3);
        probe(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        tick(1);

        // Clean press held 20 cycles, then release.
        key[0] = 1'b0;
        expect_evt(4'h1, 4'h0, cycle + LAT);
        tick(20);
        key[0] = 1'b1;
        expect_evt(4'h0, 4'h1, cycle + LAT);
        tick(15);

        // Bounce (3 low / 2 high) ending high: no events.
        repeat (8) begin
            key[1] = 1'b0;
            tick(3);
            key[1] = 1'b1;
            tick(2);
        end
        tick(15);

        // Same bounce ending low: one press 10 cycles after the last edge.
        repeat (8) begin
            key[1] = 1'b0;
            tick(3);
            key[1] = 1'b1;
            tick(2);
        end
        key[1] = 1'b0;
        expect_evt(4'h2, 4'h0, cycle + LAT);
        tick(20);
        key[1] = 1'b1;
        expect_evt(4'h0, 4'h2, cycle + LAT);
        tick(15);

        // Threshold: 7 low cycles rejected, 8 low cycles accepted.
        key[2] = 1'b0;
        tick(7);
        key[2] = 1'b1;
        tick(15);
        probe(4'h0, 4'h0, m_lvl, m_tog, 1'b0);
        tick(1);
        key[2] = 1'b0;
        expect_evt(4'h4, 4'h0, cycle + LAT);
        tick(8);
        key[2] = 1'b1;
        expect_evt(4'h0, 4'h4, cycle + LAT);
        tick(15);

        // Clean restart so toggles begin at zero for the all-keys test.
        sys_rst = 1'b1;
        m_lvl   = 4'h0;
        m_tog   = 4'h0;
        tick(1);
        probe(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        tick(1);
        sys_rst = 1'b0;
        tick(3);

        // All keys together: press, release, press, release, press.
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) begin
                key = 4'h0;
                expect_evt(4'hF, 4'h0, cycle + LAT);
            end else begin
                key = 4'hF;
                expect_evt(4'h0, 4'hF, cycle + LAT);
            end
            tick(15);
        end
        probe(4'h0, 4'h0, 4'hF, 4'hF, 1'b0);
        tick(1);

        // Asynchronous reset mid-cycle: outputs clear before any clock edge.
        #2;
        sys_rst = 1'b1;
        key     = 4'hF;
        m_lvl   = 4'h0;
        m_tog   = 4'h0;
        probe(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        tick(2);
        sys_rst = 1'b0;
        tick(3);

        // Reset during key[3] debounce; key held low is re-accepted after reset.
        key[3] = 1'b0;
        tick(7);
        sys_rst = 1'b1;
        m_lvl   = 4'h0;
        m_tog   = 4'h0;
        tick(1);
        sys_rst = 1'b0;
        expect_evt(4'h8, 4'h0, cycle + LAT);
        tick(15);

        probe(4'h0, 4'h0, m_lvl, m_tog, 1'b1);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
